round_robin_arbiter_n_locked: RTL and testbench

- Parametrised N-requester round-robin arbiter with zero-latency one-hot grant.
- Adds a downstream ready/last handshake. A grant holds ("locks") on one requester from its first accepted beat until the beat carrying last.
- Sits in front of a shared sink (bus, FIFO write port, memory) that serves multi-beat bursts from several masters.
- With N=2 and ready=last=1, its grant sequence matches the existing 2-request round-robin arbiter.

---
 rtl/round_robin_arbiter_n_locked.sv | 160 ++++++++++++++++
 tb/tb_round_robin_arbiter_n_locked.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_n_locked.sv
// round_robin_arbiter_n_locked
//   N-requester round-robin arbiter with a same-cycle one-hot grant. Once the
//   first beat of a burst is accepted without last, the grant locks onto that
//   requester until the beat that carries last is accepted.
//
// Parameters:
//   N         number of requesters (2..32)
//   MAX_BURST beat limit per lock (only with RR_ARB_BURST_LIMIT_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   requests   request vector, bit i = requester i
//   ready      downstream accepts the current beat
//   last       current beat ends the burst (sampled only on accept)
//   grants     one-hot grant or all zeros (combinational)
//   grant_idx  index of the granted requester, 0 when nothing is granted
//   locked     arbiter holds a lock
//   burst_cut  (RR_ARB_BURST_LIMIT_EN only) one-cycle pulse after a lock was
//              force-released at MAX_BURST beats
//
// Build option: define RR_ARB_BURST_LIMIT_EN to bound every lock to MAX_BURST
// accepted beats.
module round_robin_arbiter_n_locked #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         requests,
  input  logic                 ready,
  input  logic                 last,
  output logic [N-1:0]         grants,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 locked
`ifdef RR_ARB_BURST_LIMIT_EN
  ,
  output logic                 burst_cut
`endif
);

  localparam int W = $clog2(N);

  if (N < 2 || N > 32 || MAX_BURST < 1) begin : g_bad_cfg
    $error("round_robin_arbiter_n_locked: N must be 2..32 and MAX_BURST >= 1");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   owner_q, owner_d;

  logic           win_found;
  logic [W-1:0]   win_idx;
  logic           sel_valid;
  logic [W-1:0]   sel_idx;
  logic [W-1:0]   nxt_ptr;
  logic           accept;
  logic           forced;
  logic           end_burst;

  // Rotating priority scan starting at ptr; the wrap is done explicitly so a
  // non-power-of-2 N never yields an out-of-range index.
  always_comb begin
    int unsigned cand;
    logic [W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = W'(cand);
      if (!win_found && requests[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // In LOCKED only the owner can be granted, and only while it requests.
  always_comb begin
    if (state_q == LOCKED) begin
      sel_valid = requests[owner_q];
      sel_idx   = owner_q;
    end else begin
      sel_valid = win_found;
      sel_idx   = win_idx;
    end
    if (rst) sel_valid = 1'b0;
  end

  assign grants    = sel_valid ? (N'(1) << sel_idx) : '0;
  assign grant_idx = sel_valid ? sel_idx : '0;
  assign locked    = (state_q == LOCKED) && !rst;

  assign accept    = sel_valid && ready;
  assign nxt_ptr   = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
  assign end_burst = last || forced;

`ifdef RR_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cut_q;

  // The counter holds the beats already accepted in this lock, so the beat
  // seen while it equals MAX_BURST-1 is the MAX_BURST-th one.
  assign forced = accept && !last && (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = end_burst ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cut_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cut_q <= forced;
    end
  end

  assign burst_cut = cut_q;
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      if (end_burst) begin
        state_d = IDLE;
        ptr_d   = nxt_ptr;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= W'(N - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n_locked.sv
module tb_round_robin_arbiter_n_locked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0] req4;
  logic       rdy4, last4;
  logic [3:0] g4;
  logic [1:0] gi4;
  logic       lk4;

  logic [1:0] req2;
  logic       rdy2, last2;
  logic [1:0] g2;
  logic       gi2;
  logic       lk2;

`ifdef RR_ARB_BURST_LIMIT_EN
  logic       cut4, cut2;
  logic [3:0] reqb;
  logic       rdyb, lastb;
  logic [3:0] gb;
  logic [1:0] gib;
  logic       lkb, cutb;
`endif

  round_robin_arbiter_n_locked #(.N(4), .MAX_BURST(16)) u_d4 (
    .clk(clk), .rst(rst), .requests(req4), .ready(rdy4), .last(last4),
    .grants(g4), .grant_idx(gi4), .locked(lk4)
`ifdef RR_ARB_BURST_LIMIT_EN
    , .burst_cut(cut4)
`endif
  );

  round_robin_arbiter_n_locked #(.N(2), .MAX_BURST(16)) u_d2 (
    .clk(clk), .rst(rst), .requests(req2), .ready(rdy2), .last(last2),
    .grants(g2), .grant_idx(gi2), .locked(lk2)
`ifdef RR_ARB_BURST_LIMIT_EN
    , .burst_cut(cut2)
`endif
  );

`ifdef RR_ARB_BURST_LIMIT_EN
  round_robin_arbiter_n_locked #(.N(4), .MAX_BURST(4)) u_db (
    .clk(clk), .rst(rst), .requests(reqb), .ready(rdyb), .last(lastb),
    .grants(gb), .grant_idx(gib), .locked(lkb), .burst_cut(cutb)
  );
`endif

  typedef struct {
    int unsigned dut;
    logic [3:0]  g;
    logic [1:0]  idx;
    logic        lk;
    logic        cut;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] ag;
  logic [1:0] ai;
  logic       al, ac;

  // Monitor: every expected entry queued during this cycle is compared against
  // the DUT outputs mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      ag = '0; ai = '0; al = 1'b0; ac = 1'b0;
      case (e.dut)
        0: begin ag = g4; ai = gi4; al = lk4; end
        1: begin ag = {2'b00, g2}; ai = {1'b0, gi2}; al = lk2; end
`ifdef RR_ARB_BURST_LIMIT_EN
        2: begin ag = gb; ai = gib; al = lkb; ac = cutb; end
`endif
        default: ;
      endcase
      checks++;
      if (ag !== e.g || ai !== e.idx || al !== e.lk || ac !== e.cut) begin
        failures++;
        $display("FAIL %s: got grants=%b idx=%0d locked=%b cut=%b, want grants=%b idx=%0d locked=%b cut=%b",
                 e.name, ag, ai, al, ac, e.g, e.idx, e.lk, e.cut);
      end
    end
  end

  task automatic push(input int unsigned d, input logic [3:0] g, input logic [1:0] idx,
                      input logic lk, input logic cut, input string nm);
    exp_t e;
    e.dut = d; e.g = g; e.idx = idx; e.lk = lk; e.cut = cut; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c4(input logic [3:0] r, input logic rd, input logic ls,
                    input logic [3:0] eg, input logic [1:0] ei, input logic el, input string nm);
    req4 = r; rdy4 = rd; last4 = ls;
    push(0, eg, ei, el, 1'b0, nm);
    tick();
  endtask

`ifdef RR_ARB_BURST_LIMIT_EN
  task automatic cb(input logic [3:0] r, input logic rd, input logic ls,
                    input logic [3:0] eg, input logic [1:0] ei, input logic el,
                    input logic ec, input string nm);
    reqb = r; rdyb = rd; lastb = ls;
    push(2, eg, ei, el, ec, nm);
    tick();
  endtask
`endif

  logic [1:0] r2v [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] e2v [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
  logic [3:0] ea  [5]  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] eai [5]  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset held with everybody requesting: outputs must be gated to zero.
    rst  = 1'b1;
    req4 = 4'b1111; rdy4 = 1'b1; last4 = 1'b0;
    req2 = 2'b11;   rdy2 = 1'b1; last2 = 1'b1;
`ifdef RR_ARB_BURST_LIMIT_EN
    reqb = 4'b1111; rdyb = 1'b1; lastb = 1'b0;
    push(2, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_b");
`endif
    push(0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_d4");
    push(1, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_d2");
    tick();
    tick();
    rst  = 1'b0;
    req4 = '0; req2 = '0;
`ifdef RR_ARB_BURST_LIMIT_EN
    reqb = '0;
`endif

    // N=2 sequence with ready=last=1.
    for (int i = 0; i < 10; i++) begin
      req2 = r2v[i];
      push(1, {2'b00, e2v[i]}, {1'b0, (e2v[i] == 2'b10)}, 1'b0, 1'b0, $sformatf("n2_seq%0d", i));
      tick();
    end
    req2 = '0;

    // N=4 full contention after reset: highest index first, then rotate.
    for (int i = 0; i < 5; i++) c4(4'b1111, 1'b1, 1'b1, ea[i], eai[i], 1'b0, $sformatf("full_rot%0d", i));
    c4(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, "ptr_setup");
    c4(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, "idle_no_accept");

    // Locked burst on requester 1, four beats.
    c4(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "burst_beat1");
    c4(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, "burst_beat2");
    c4(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, "burst_beat3");
    c4(4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, "burst_last");
    c4(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, "burst_next_arb");

    // Owner drops its request mid-burst: lock held, grant resumes.
    c4(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "drop_start");
    c4(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "drop_gap1");
    c4(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "drop_gap2");
    c4(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, "drop_resume");

    // Backpressure: last without ready must not release; others never granted.
    for (int i = 0; i < 4; i++) c4(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, $sformatf("stall%0d", i));

    // Reset mid-burst drops the lock immediately.
    req4 = 4'b1111; rdy4 = 1'b1; last4 = 1'b0;
    rst  = 1'b1;
    push(0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid_burst");
    tick();
    rst = 1'b0;
    c4(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, "post_rst_ptr");

    // Lock on requester 3, release wraps the pointer to 0.
    c4(4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, "wrap_lock3");
    c4(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, "wrap_last");
    c4(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, "wrap_ptr0");
    req4 = '0;

`ifdef RR_ARB_BURST_LIMIT_EN
    // MAX_BURST=4: fourth beat without last forces a release.
    cb(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0, "bl_setup");
    cb(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, "bl_beat1");
    cb(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "bl_beat2");
    cb(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "bl_beat3");
    cb(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "bl_beat4");
    cb(4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, "bl_cut");
    cb(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "bl_after");
    reqb = '0;
`endif

    tick();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
